// File: rtl/uart_bridge_pkg.sv
// Shared types and sizes for the UART stream bridge: FSM state encodings and
// skid-buffer geometry.
package uart_bridge_pkg;

   localparam int BYTE_W     = 8;
   localparam int SKID_DEPTH = 2;
   localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_WR,
      TX_WAIT
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_RD,
      RX_LAT
   } rx_state_e;

endpackage

// File: rtl/uart_bridge_skid.sv
// Two-entry valid/ready skid buffer with registered outputs. Entry 0 is always
// the head, so m_data comes straight from a flop and only moves on a pop.
module uart_bridge_skid
   import uart_bridge_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic [BYTE_W-1:0] s_data,
   output logic              m_valid,
   output logic [BYTE_W-1:0] m_data,
   input  logic              m_ready,
   output logic [OCC_W-1:0]  occ
);

   logic [BYTE_W-1:0] mem_q [SKID_DEPTH];
   logic [BYTE_W-1:0] mem_d [SKID_DEPTH];
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              pop;

   assign pop = (occ_q != '0) && m_ready;

   always_comb begin
      mem_d = mem_q;
      occ_d = occ_q;
      if (pop) begin
         mem_d[0] = mem_q[1];
         occ_d    = occ_q - 1'b1;
      end
      // The write slot is chosen after the pop, so push+pop at full is legal.
      if (s_valid && occ_d != OCC_W'(SKID_DEPTH)) begin
         if (occ_d == '0) begin
            mem_d[0] = s_data;
         end else begin
            mem_d[1] = s_data;
         end
         occ_d = occ_d + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= '0;
         for (int i = 0; i < SKID_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         occ_q <= occ_d;
         for (int i = 0; i < SKID_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign m_valid = (occ_q != '0);
   assign m_data  = mem_q[0];
   assign occ     = occ_q;

endmodule

// File: rtl/uart_stream_bridge.sv
// Valid/ready byte-stream adapter onto the UART_IP tx_flag/rx_flag FIFO interface.
// Optional RX idle-timeout pulse is built only when UART_BRIDGE_TIMEOUT_EN is defined.
module uart_stream_bridge
   import uart_bridge_pkg::*;
#(
   parameter int RD_LAT      = 1,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              s_tx_valid,
   input  logic [BYTE_W-1:0] s_tx_data,
   output logic              s_tx_ready,
   input  logic              tx_fifo_full,
   output logic              tx_flag,
   output logic [BYTE_W-1:0] TBR_o,
   input  logic              rx_fifo_empty,
   output logic              rx_flag,
   input  logic [BYTE_W-1:0] RBR_i,
   output logic              m_rx_valid,
   output logic [BYTE_W-1:0] m_rx_data,
   input  logic              m_rx_ready,
   output logic [CNT_W-1:0]  tx_count,
   output logic [CNT_W-1:0]  rx_count,
   output logic              rx_timeout
);

   localparam int LAT_W = 2;

   tx_state_e         tx_state_q, tx_state_d;
   logic              tx_flag_q, tx_flag_d;
   logic [BYTE_W-1:0] tbr_q, tbr_d;
   logic [CNT_W-1:0]  tx_count_q, tx_count_d;

   rx_state_e         rx_state_q, rx_state_d;
   logic              rx_flag_q, rx_flag_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [CNT_W-1:0]  rx_count_q, rx_count_d;
   logic              push;
   logic [OCC_W-1:0]  occ;

   // Ready is masked during reset so every output reads 0 while rst is high.
   assign s_tx_ready = !rst && (tx_state_q == TX_IDLE) && !tx_fifo_full;

   always_comb begin
      tx_state_d = tx_state_q;
      tbr_d      = tbr_q;
      tx_flag_d  = 1'b0;
      tx_count_d = tx_count_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (s_tx_valid && s_tx_ready) begin
               tx_state_d = TX_WR;
               tbr_d      = s_tx_data;
               tx_flag_d  = 1'b1;
            end
         end
         TX_WR: begin
            tx_state_d = TX_WAIT;
            tx_count_d = tx_count_q + 1'b1;
         end
         TX_WAIT: tx_state_d = TX_IDLE;
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         tx_flag_q  <= 1'b0;
         tbr_q      <= '0;
         tx_count_q <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_flag_q  <= tx_flag_d;
         tbr_q      <= tbr_d;
         tx_count_q <= tx_count_d;
      end
   end

   // A read starts only with a free skid slot, and only one is ever in flight.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_flag_d  = 1'b0;
      lat_d      = lat_q;
      push       = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_fifo_empty && occ < OCC_W'(SKID_DEPTH)) begin
               rx_state_d = RX_RD;
               rx_flag_d  = 1'b1;
            end
         end
         RX_RD: begin
            rx_state_d = RX_LAT;
            lat_d      = '0;
         end
         RX_LAT: begin
            if (lat_q == LAT_W'(RD_LAT - 1)) begin
               push       = 1'b1;
               rx_state_d = RX_IDLE;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_count_d = rx_count_q;
      if (m_rx_valid && m_rx_ready) begin
         rx_count_d = rx_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_q <= RX_IDLE;
         rx_flag_q  <= 1'b0;
         lat_q      <= '0;
         rx_count_q <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_flag_q  <= rx_flag_d;
         lat_q      <= lat_d;
         rx_count_q <= rx_count_d;
      end
   end

   uart_bridge_skid u_skid (
      .clk     (clk),
      .rst     (rst),
      .s_valid (push),
      .s_data  (RBR_i),
      .m_valid (m_rx_valid),
      .m_data  (m_rx_data),
      .m_ready (m_rx_ready),
      .occ     (occ)
   );

`ifdef UART_BRIDGE_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic              armed_q, armed_d;
   logic              rx_timeout_q, rx_timeout_d;

   // Armed by each push and disarmed by the pulse: one timeout per burst.
   always_comb begin
      idle_cnt_d   = idle_cnt_q;
      armed_d      = armed_q;
      rx_timeout_d = 1'b0;
      if (push) begin
         idle_cnt_d = '0;
         armed_d    = 1'b1;
      end else if (armed_q && rx_fifo_empty && rx_state_q == RX_IDLE) begin
         idle_cnt_d = idle_cnt_q + 1'b1;
         if (idle_cnt_d == IDLE_W'(TIMEOUT_CYC)) begin
            rx_timeout_d = 1'b1;
            armed_d      = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt_q   <= '0;
         armed_q      <= 1'b0;
         rx_timeout_q <= 1'b0;
      end else begin
         idle_cnt_q   <= idle_cnt_d;
         armed_q      <= armed_d;
         rx_timeout_q <= rx_timeout_d;
      end
   end

   assign rx_timeout = rx_timeout_q;
`else
   assign rx_timeout = 1'b0 & (TIMEOUT_CYC != 0);
`endif

   assign tx_flag  = tx_flag_q;
   assign TBR_o    = tbr_q;
   assign tx_count = tx_count_q;
   assign rx_flag  = rx_flag_q;
   assign rx_count = rx_count_q;

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Directed bench for uart_stream_bridge with a small UART FIFO model (RD_LAT=1).
// Timeout checks follow UART_BRIDGE_TIMEOUT_EN.
module tb_uart_stream_bridge;

   localparam int CNT_W = 16;
`ifdef UART_BRIDGE_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 1024;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             s_tx_valid = 1'b0;
   logic [7:0]       s_tx_data = 8'h00;
   logic             s_tx_ready;
   logic             tx_fifo_full = 1'b0;
   logic             tx_flag;
   logic [7:0]       TBR_o;
   logic             rx_fifo_empty;
   logic             rx_flag;
   logic [7:0]       RBR_i = 8'h00;
   logic             m_rx_valid;
   logic [7:0]       m_rx_data;
   logic             m_rx_ready = 1'b0;
   logic [CNT_W-1:0] tx_count, rx_count;
   logic             rx_timeout;

   int checks = 0;
   int errors = 0;

   logic [7:0] rxq[$];
   logic [7:0] txlog[$];
   int         rx_n = 0;
   bit         loopback = 1'b0;

   always #5 clk = ~clk;

   uart_stream_bridge #(
      .RD_LAT      (1),
      .TIMEOUT_CYC (TMO),
      .CNT_W       (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_tx_valid    (s_tx_valid),
      .s_tx_data     (s_tx_data),
      .s_tx_ready    (s_tx_ready),
      .tx_fifo_full  (tx_fifo_full),
      .tx_flag       (tx_flag),
      .TBR_o         (TBR_o),
      .rx_fifo_empty (rx_fifo_empty),
      .rx_flag       (rx_flag),
      .RBR_i         (RBR_i),
      .m_rx_valid    (m_rx_valid),
      .m_rx_data     (m_rx_data),
      .m_rx_ready    (m_rx_ready),
      .tx_count      (tx_count),
      .rx_count      (rx_count),
      .rx_timeout    (rx_timeout)
   );

   // UART FIFO model: a read strobe makes RBR_i hold the popped byte one cycle later.
   always @(posedge clk) begin
      if (rx_flag && rxq.size() > 0) RBR_i <= rxq.pop_front();
      if (tx_flag) begin
         if (loopback) rxq.push_back(TBR_o);
         else          txlog.push_back(TBR_o);
      end
      rx_n <= rxq.size();
   end
   assign rx_fifo_empty = (rx_n == 0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      txlog.delete();
      rxq.delete();
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic send(input logic [7:0] b, input string tag);
      int n = 0;
      s_tx_valid = 1'b1;
      s_tx_data  = b;
      #1;
      while (!s_tx_ready && n < 100) begin
         tick();
         #1;
         n++;
      end
      check({tag, "_ready"}, 32'(s_tx_ready), 1);
      tick();
      s_tx_valid = 1'b0;
   endtask

   task automatic recv(input logic [7:0] b, input string tag);
      int n = 0;
      m_rx_ready = 1'b1;
      while (!m_rx_valid && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 32'(m_rx_valid), 1);
      check({tag, "_data"}, 32'(m_rx_data), 32'(b));
      tick();
      m_rx_ready = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int         nflag, bad, npulse, first, n;
      logic [7:0] b;

      // Reset state, sampled while rst is still high
      tick();
      check("rst_s_tx_ready", 32'(s_tx_ready), 0);
      check("rst_tx_flag", 32'(tx_flag), 0);
      check("rst_tbr", 32'(TBR_o), 0);
      check("rst_rx_flag", 32'(rx_flag), 0);
      check("rst_m_rx_valid", 32'(m_rx_valid), 0);
      check("rst_m_rx_data", 32'(m_rx_data), 0);
      check("rst_counts", {tx_count, rx_count}, 0);
      check("rst_timeout", 32'(rx_timeout), 0);
      rst = 1'b0;
      tick();

      // 1: two back-to-back bytes, strobes at cycles 1 and 4 after the first handshake
      s_tx_valid = 1'b1;
      s_tx_data  = 8'hA5;
      #1;
      check("t1_ready_idle", 32'(s_tx_ready), 1);
      tick();
      check("t1_flag_c1", 32'(tx_flag), 1);
      check("t1_tbr_c1", 32'(TBR_o), 'hA5);
      check("t1_ready_busy", 32'(s_tx_ready), 0);
      s_tx_data = 8'h3C;
      tick();
      check("t1_flag_c2", 32'(tx_flag), 0);
      tick();
      check("t1_flag_c3", 32'(tx_flag), 0);
      check("t1_ready_c3", 32'(s_tx_ready), 1);
      tick();
      check("t1_flag_c4", 32'(tx_flag), 1);
      check("t1_tbr_c4", 32'(TBR_o), 'h3C);
      s_tx_valid = 1'b0;
      tick();
      check("t1_flag_c5", 32'(tx_flag), 0);
      check("t1_tx_count", 32'(tx_count), 2);
      check("t1_log_size", 32'(txlog.size()), 2);
      check("t1_log0", 32'(txlog[0]), 'hA5);
      check("t1_log1", 32'(txlog[1]), 'h3C);

      // 2: TX FIFO full blocks the handshake; releasing it gives exactly one write
      tx_fifo_full = 1'b1;
      s_tx_valid   = 1'b1;
      s_tx_data    = 8'h5A;
      bad = 0;
      repeat (50) begin
         tick();
         if (s_tx_ready || tx_flag) bad++;
      end
      check("t2_blocked", 32'(bad), 0);
      tx_fifo_full = 1'b0;
      #1;
      check("t2_ready_release", 32'(s_tx_ready), 1);
      tick();
      s_tx_valid = 1'b0;
      nflag = int'(tx_flag);
      repeat (10) begin
         tick();
         nflag += int'(tx_flag);
      end
      check("t2_writes", 32'(nflag), 1);
      check("t2_tx_count", 32'(tx_count), 3);
      check("t2_log2", 32'(txlog[2]), 'h5A);

      // 3: three bytes waiting, sink stalled: two reads, then a third only after a pop
      rxq.push_back(8'h11);
      rxq.push_back(8'h22);
      rxq.push_back(8'h33);
      nflag = 0;
      repeat (20) begin
         tick();
         nflag += int'(rx_flag);
      end
      check("t3_reads_stalled", 32'(nflag), 2);
      check("t3_valid", 32'(m_rx_valid), 1);
      check("t3_head", 32'(m_rx_data), 'h11);
      check("t3_rx_count0", 32'(rx_count), 0);
      m_rx_ready = 1'b1;
      tick();
      m_rx_ready = 1'b0;
      check("t3_head_after_pop", 32'(m_rx_data), 'h22);
      nflag = 0;
      repeat (20) begin
         tick();
         nflag += int'(rx_flag);
      end
      check("t3_third_read", 32'(nflag), 1);
      check("t3_head_stable", 32'(m_rx_data), 'h22);
      check("t3_rx_count1", 32'(rx_count), 1);
      recv(8'h22, "t3_b2");
      recv(8'h33, "t3_b3");
      tick();
      check("t3_drained", 32'(m_rx_valid), 0);
      check("t3_rx_count3", 32'(rx_count), 3);

      // 4: loopback of 256 random bytes
      reset_dut();
      loopback = 1'b1;
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom_range(0, 255));
         send(b, $sformatf("t4_tx%0d", i));
         recv(b, $sformatf("t4_rx%0d", i));
      end
      loopback = 1'b0;
      check("t4_tx_count", 32'(tx_count), 256);
      check("t4_rx_count", 32'(rx_count), 256);

      // 5a: reset asserted while the second read is in RX_LAT
      reset_dut();
      rxq.push_back(8'h77);
      rxq.push_back(8'h88);
      nflag = 0;
      n = 0;
      while (nflag < 2 && n < 50) begin
         tick();
         nflag += int'(rx_flag);
         n++;
      end
      check("t5_second_read", 32'(nflag), 2);
      tick();
      check("t5_valid_before", 32'(m_rx_valid), 1);
      rst = 1'b1;
      #1;
      check("t5_rx_flag", 32'(rx_flag), 0);
      check("t5_m_rx_valid", 32'(m_rx_valid), 0);
      check("t5_m_rx_data", 32'(m_rx_data), 0);
      check("t5_timeout", 32'(rx_timeout), 0);
      tick();
      tick();
      rst = 1'b0;
      bad = 0;
      repeat (10) begin
         tick();
         bad += int'(rx_flag) + int'(tx_flag) + int'(m_rx_valid);
      end
      check("t5_no_rx_strobe", 32'(bad), 0);

      // 5b: reset asserted during TX_WR drops the byte
      txlog.delete();
      send(8'hC3, "t5b");
      check("t5b_flag_before", 32'(tx_flag), 1);
      check("t5b_tbr_before", 32'(TBR_o), 'hC3);
      rst = 1'b1;
      #1;
      check("t5b_tx_flag", 32'(tx_flag), 0);
      check("t5b_tbr", 32'(TBR_o), 0);
      check("t5b_ready", 32'(s_tx_ready), 0);
      check("t5b_tx_count", 32'(tx_count), 0);
      tick();
      tick();
      rst = 1'b0;
      bad = 0;
      repeat (10) begin
         tick();
         bad += int'(tx_flag);
      end
      check("t5b_no_tx_strobe", 32'(bad), 0);
      check("t5b_dropped", 32'(txlog.size()), 0);

      // 6: one byte then idle; timeout pulse only when the feature is built
      rxq.push_back(8'h9E);
      m_rx_ready = 1'b1;
      n = 0;
      while (!m_rx_valid && n < 50) begin
         tick();
         n++;
      end
      check("t6_valid", 32'(m_rx_valid), 1);
      check("t6_data", 32'(m_rx_data), 'h9E);
      npulse = 0;
      first  = 0;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (rx_timeout) begin
            npulse++;
            if (first == 0) first = i;
         end
      end
      m_rx_ready = 1'b0;
`ifdef UART_BRIDGE_TIMEOUT_EN
      check("t6_pulses", 32'(npulse), 1);
      check("t6_delay", 32'(first), 16);
`else
      check("t6_pulses", 32'(npulse), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
